// File: rtl/gfx_pkg.sv
// gfx_pkg: shared types and constants for the screen RAM arbiter and its FIFO.
//   arb_state_t / ST_*  : arbiter FSM encoding (RUN, PEND, CLEAR)
//   grant_e             : per-cycle RAM port owner
//   CLR_WORDS_DEFAULT   : words cleared by default (80x60 text screen)
package gfx_pkg;

  localparam int unsigned TEXT_COLS         = 80;
  localparam int unsigned TEXT_ROWS         = 60;
  localparam int unsigned CLR_WORDS_DEFAULT = TEXT_COLS * TEXT_ROWS;

  // Arbiter state encoding
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_RUN   = 2'd0;
  localparam arb_state_t ST_PEND  = 2'd1;
  localparam arb_state_t ST_CLEAR = 2'd2;

  // RAM port owner for the current cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_CLR  = 2'd2,
    GNT_HOST = 2'd3
  } grant_e;

endpackage

// File: rtl/gfx_wr_fifo.sv
// gfx_wr_fifo: synchronous FIFO holding buffered host RAM writes.
// Ports:
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push, din  : write strobe and {addr, data} payload (ignored when full)
//   pop        : remove head entry (ignored when empty)
//   head_c     : current head entry (combinational read of storage)
//   empty_c    : no entries held
//   count      : registered occupancy, 0..DEPTH
module gfx_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  assign empty_c = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign head_c  = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy update; pointers wrap naturally (power-of-two depth)
  always_comb begin
    wr_en    = push && !full;
    rd_en    = pop && !empty_c;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_en && !rd_en)      count_d = count_q + CNT_W'(1);
    else if (!wr_en && rd_en) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/screen_ram_arbiter.sv
// screen_ram_arbiter: owns the screen RAM port and shares it between display
// reads (absolute priority), the clear-screen fill engine and buffered host
// writes. Optional clear engine is built when SCREEN_CLEAR_EN is defined;
// otherwise clr_start/clr_data are ignored and clr_busy/clr_done stay 0.
// Ports:
//   clk, rst_n                        : pixel clock, async active-low reset
//   disp_req, disp_addr               : display read request
//   disp_rdata, disp_rvalid           : read data (ram_q gated by valid), valid 2 cycles after req
//   host_wr_valid/ready/addr/data     : host write handshake into the FIFO
//   clr_start, clr_data               : clear request and fill value
//   clr_busy, clr_done                : clear pending/running, completion pulse
//   fifo_level                        : host FIFO occupancy
//   ram_addr, ram_wdata, ram_we, ram_q: registered RAM port, RAM read data
module screen_ram_arbiter
  import gfx_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CLR_WORDS  = CLR_WORDS_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          disp_req,
  input  logic [ADDR_W-1:0]             disp_addr,
  output logic [DATA_W-1:0]             disp_rdata,
  output logic                          disp_rvalid,
  input  logic                          host_wr_valid,
  output logic                          host_wr_ready,
  input  logic [ADDR_W-1:0]             host_wr_addr,
  input  logic [DATA_W-1:0]             host_wr_data,
  input  logic                          clr_start,
  input  logic [DATA_W-1:0]             clr_data,
  output logic                          clr_busy,
  output logic                          clr_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic                          ram_we,
  input  logic [DATA_W-1:0]             ram_q
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PAY_W = ADDR_W + DATA_W;

  arb_state_t        state_q, state_d;
  grant_e            grant;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] clr_data_q, clr_data_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              rvalid1_q, rvalid1_d;
  logic              rvalid2_q, rvalid2_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              host_push;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [PAY_W-1:0]  fifo_head;
  logic [PAY_W-1:0]  host_head;
  logic [LVL_W-1:0]  fifo_cnt;
  logic [LVL_W-1:0]  level_nxt;

  gfx_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAY_W)
  ) u_wr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .din     ({host_wr_addr, host_wr_data}),
    .pop     (fifo_pop),
    .head_c  (fifo_head),
    .empty_c (fifo_empty),
    .count   (fifo_cnt)
  );

`ifndef SCREEN_CLEAR_EN
  logic unused_clr;
  assign unused_clr = ^{clr_start, clr_data};
`endif

  // Grant selection, RAM port next values and FSM next state
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_data_d  = clr_data_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    done_d      = 1'b0;
    grant       = GNT_NONE;
    rvalid1_d   = disp_req;
    rvalid2_d   = rvalid1_q;

    host_push = host_wr_valid && ready_q;
    // An empty FIFO lets a just-offered write go straight to the RAM port
    host_head = fifo_empty ? {host_wr_addr, host_wr_data} : fifo_head;

    if (disp_req) begin
      grant      = GNT_DISP;
      ram_addr_d = disp_addr;
    end else if (state_q == ST_CLEAR) begin
      grant       = GNT_CLR;
      ram_addr_d  = clr_cnt_q;
      ram_wdata_d = clr_data_q;
      ram_we_d    = 1'b1;
    end else if (!fifo_empty || host_push) begin
      grant       = GNT_HOST;
      ram_addr_d  = host_head[PAY_W-1:DATA_W];
      ram_wdata_d = host_head[DATA_W-1:0];
      ram_we_d    = 1'b1;
    end

    fifo_pop  = (grant == GNT_HOST) && !fifo_empty;
    fifo_push = host_push && !((grant == GNT_HOST) && fifo_empty);

`ifdef SCREEN_CLEAR_EN
    case (state_q)
      ST_RUN: begin
        if (clr_start) begin
          state_d    = ST_PEND;
          clr_data_d = clr_data;
        end
      end
      ST_PEND: begin
        // Host writes accepted before the start drain first
        if (fifo_empty) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        if (grant == GNT_CLR) begin
          if (clr_cnt_q == ADDR_W'(CLR_WORDS - 1)) begin
            state_d   = ST_RUN;
            clr_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
`else
    state_d = ST_RUN;
`endif

    level_nxt = fifo_cnt + LVL_W'(fifo_push) - LVL_W'(fifo_pop);
    ready_d   = (state_d == ST_RUN) && (level_nxt != LVL_W'(FIFO_DEPTH));
    busy_d    = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      clr_cnt_q   <= '0;
      clr_data_q  <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      rvalid1_q   <= 1'b0;
      rvalid2_q   <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_data_q  <= clr_data_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      rvalid1_q   <= rvalid1_d;
      rvalid2_q   <= rvalid2_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign ram_we        = ram_we_q;
  assign disp_rvalid   = rvalid2_q;
  // Gated so the data output is also 0 in reset and between reads
  assign disp_rdata    = rvalid2_q ? ram_q : '0;
  assign host_wr_ready = ready_q;
  assign clr_busy      = busy_q;
  assign clr_done      = done_q;
  assign fifo_level    = fifo_cnt;

endmodule
